// File: rtl/snn_lif_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron array.
//   lif_state_e  : sweep controller states
//   Leak*        : leak_mode encodings (LeakRsvd behaves like LeakNone)
//   sat_max/min  : two's-complement saturation limits for a given width, returned
//                  zero-extended in 64 bits; callers keep the low `width` bits.
package snn_lif_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDone  = 2'd2
  } lif_state_e;

  localparam logic [1:0] LeakNone   = 2'd0;
  localparam logic [1:0] LeakShift  = 2'd1;
  localparam logic [1:0] LeakLinear = 2'd2;
  localparam logic [1:0] LeakRsvd   = 2'd3;

  function automatic logic [63:0] sat_max(int unsigned width);
    sat_max = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(int unsigned width);
    sat_min = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/lif_update_ac.sv
// Combinational per-neuron timestep update: refractory countdown, leak, threshold.
// Ports:
//   v_in, cnt_in                : current membrane potential and refractory counter
//   leak_mode, leak_const       : leak selection and linear leak magnitude
//   threshold, reset_potential  : firing threshold and post-spike / refractory potential
//   refrac_cycles               : counter value loaded on a spike
//   v_out, cnt_out, spike       : next state and spike flag
module lif_update_ac
  import snn_lif_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned REFRAC_WIDTH = 4,
  parameter int unsigned LEAK_SHIFT   = 4
) (
  input  logic signed [DATA_WIDTH-1:0]   v_in,
  input  logic        [REFRAC_WIDTH-1:0] cnt_in,
  input  logic        [1:0]              leak_mode,
  input  logic        [DATA_WIDTH-1:0]   leak_const,
  input  logic signed [DATA_WIDTH-1:0]   threshold,
  input  logic signed [DATA_WIDTH-1:0]   reset_potential,
  input  logic        [REFRAC_WIDTH-1:0] refrac_cycles,
  output logic signed [DATA_WIDTH-1:0]   v_out,
  output logic        [REFRAC_WIDTH-1:0] cnt_out,
  output logic                           spike
);

  logic signed [DATA_WIDTH:0]   vx;
  logic signed [DATA_WIDTH:0]   lx;
  logic signed [DATA_WIDTH:0]   lin_dn;
  logic signed [DATA_WIDTH:0]   lin_up;
  logic signed [DATA_WIDTH-1:0] leaked;

  always_comb begin
    vx     = {v_in[DATA_WIDTH-1], v_in};
    lx     = {1'b0, leak_const};
    lin_dn = vx - lx;
    lin_up = vx + lx;

    leaked = v_in;
    case (leak_mode)
      LeakShift: leaked = v_in - (v_in >>> LEAK_SHIFT);
      LeakLinear: begin
        // Move toward zero but never across it.
        if (!vx[DATA_WIDTH] && (vx != '0)) begin
          leaked = (!lin_dn[DATA_WIDTH] && (lin_dn != '0)) ? lin_dn[DATA_WIDTH-1:0] : '0;
        end else if (vx[DATA_WIDTH]) begin
          leaked = lin_up[DATA_WIDTH] ? lin_up[DATA_WIDTH-1:0] : '0;
        end else begin
          leaked = '0;
        end
      end
      LeakNone, LeakRsvd: leaked = v_in;
      default: leaked = v_in;
    endcase

    v_out   = leaked;
    cnt_out = '0;
    spike   = 1'b0;
    if (cnt_in != '0) begin
      // Refractory neurons are clamped and skip leak and threshold entirely.
      v_out   = reset_potential;
      cnt_out = cnt_in - REFRAC_WIDTH'(1);
    end else if (leaked >= threshold) begin
      v_out   = reset_potential;
      cnt_out = refrac_cycles;
      spike   = 1'b1;
    end
  end

endmodule

// File: rtl/lif_neuron_array_ac.sv
// Array of leaky integrate-and-fire neurons sharing one accumulate-only datapath.
// Synaptic events are integrated while idle; a timestep request sweeps every neuron
// once (leak, threshold, refractory) and emits spikes through a ready/valid port.
// Ports:
//   clk, rst_n                              : clock, async active-low reset
//   ev_valid/ev_ready, ev_neuron_id,
//   ev_weight, ev_excitatory                : synaptic event input (accepted in idle only)
//   step_start / step_done                  : timestep request / end-of-sweep pulse
//   leak_mode, leak_const, threshold,
//   reset_potential, refrac_cycles          : neuron model configuration
//   spk_valid/spk_ready, spk_neuron_id      : spike output
//   rd_addr / rd_vmem                       : membrane readback, one-cycle latency
//   ac_op_count, refrac_drop_count,
//   spike_count, stats_clear                : statistics counters and clear
module lif_neuron_array_ac
  import snn_lif_pkg::*;
#(
  parameter int unsigned NUM_NEURONS  = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned LEAK_SHIFT   = 4,
  parameter int unsigned REFRAC_WIDTH = 4,
  parameter int unsigned ID_WIDTH     = $clog2(NUM_NEURONS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic        [ID_WIDTH-1:0]     ev_neuron_id,
  input  logic signed [WEIGHT_WIDTH-1:0] ev_weight,
  input  logic                           ev_excitatory,
  input  logic                           step_start,
  output logic                           step_done,
  input  logic        [1:0]              leak_mode,
  input  logic        [DATA_WIDTH-1:0]   leak_const,
  input  logic signed [DATA_WIDTH-1:0]   threshold,
  input  logic signed [DATA_WIDTH-1:0]   reset_potential,
  input  logic        [REFRAC_WIDTH-1:0] refrac_cycles,
  output logic                           spk_valid,
  input  logic                           spk_ready,
  output logic        [ID_WIDTH-1:0]     spk_neuron_id,
  input  logic        [ID_WIDTH-1:0]     rd_addr,
  output logic signed [DATA_WIDTH-1:0]   rd_vmem,
  output logic        [31:0]             ac_op_count,
  output logic        [31:0]             refrac_drop_count,
  output logic        [31:0]             spike_count,
  input  logic                           stats_clear
);

  localparam logic [ID_WIDTH-1:0]          LastId = ID_WIDTH'(NUM_NEURONS - 1);
  localparam logic signed [DATA_WIDTH-1:0] VMax   = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] VMin   = DATA_WIDTH'(sat_min(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH:0]   VMaxX  = {1'b0, VMax};
  localparam logic signed [DATA_WIDTH:0]   VMinX  = {1'b1, VMin};

  // Neuron state: plain register arrays.
  logic signed [DATA_WIDTH-1:0]   v_q   [NUM_NEURONS];
  logic        [REFRAC_WIDTH-1:0] cnt_q [NUM_NEURONS];

  lif_state_e                   state_q;
  logic        [ID_WIDTH-1:0]   idx_q;
  logic                         swept_q;  // all neurons updated, draining last spike
  logic                         spk_valid_q;
  logic        [ID_WIDTH-1:0]   spk_id_q;
  logic                         step_done_q;
  logic signed [DATA_WIDTH-1:0] rd_vmem_q;
  logic        [31:0]           ac_q, drop_q, spk_cnt_q;

  // Event integration
  logic                         ev_fire;
  logic                         ev_refrac;
  logic signed [DATA_WIDTH:0]   ev_vx, ev_wx, ev_sum;
  logic signed [DATA_WIDTH-1:0] ev_v_new;

  always_comb begin
    ev_fire   = ev_valid && (state_q == StIdle);
    ev_refrac = (cnt_q[ev_neuron_id] != '0);
    ev_vx     = {v_q[ev_neuron_id][DATA_WIDTH-1], v_q[ev_neuron_id]};
    ev_wx     = {{(DATA_WIDTH + 1 - WEIGHT_WIDTH){ev_weight[WEIGHT_WIDTH-1]}}, ev_weight};
    ev_sum    = ev_excitatory ? (ev_vx + ev_wx) : (ev_vx - ev_wx);
    if (ev_sum > VMaxX) begin
      ev_v_new = VMax;
    end else if (ev_sum < VMinX) begin
      ev_v_new = VMin;
    end else begin
      ev_v_new = ev_sum[DATA_WIDTH-1:0];
    end
  end

  // Sweep update for the neuron under the index
  logic signed [DATA_WIDTH-1:0]   upd_v;
  logic        [REFRAC_WIDTH-1:0] upd_cnt;
  logic                           upd_spike;
  logic                           sweeping;
  logic                           stall;

  lif_update_ac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .REFRAC_WIDTH(REFRAC_WIDTH),
    .LEAK_SHIFT  (LEAK_SHIFT)
  ) u_update (
    .v_in           (v_q[idx_q]),
    .cnt_in         (cnt_q[idx_q]),
    .leak_mode      (leak_mode),
    .leak_const     (leak_const),
    .threshold      (threshold),
    .reset_potential(reset_potential),
    .refrac_cycles  (refrac_cycles),
    .v_out          (upd_v),
    .cnt_out        (upd_cnt),
    .spike          (upd_spike)
  );

  always_comb begin
    sweeping = (state_q == StSweep) && !swept_q;
    // Only a second spike needs the output register; non-spiking neurons proceed.
    stall    = spk_valid_q && !spk_ready && upd_spike;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      swept_q     <= 1'b0;
      spk_valid_q <= 1'b0;
      spk_id_q    <= '0;
      step_done_q <= 1'b0;
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
        v_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      step_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ev_fire && !ev_refrac) begin
            v_q[ev_neuron_id] <= ev_v_new;
          end
          if (step_start) begin
            state_q <= StSweep;
            idx_q   <= '0;
            swept_q <= 1'b0;
          end
        end
        StSweep: begin
          if (!swept_q) begin
            if (!stall) begin
              v_q[idx_q]   <= upd_v;
              cnt_q[idx_q] <= upd_cnt;
              if (upd_spike) begin
                spk_valid_q <= 1'b1;
                spk_id_q    <= idx_q;
              end else if (spk_ready) begin
                spk_valid_q <= 1'b0;
              end
              if (idx_q == LastId) begin
                idx_q <= '0;
                if (!upd_spike && (!spk_valid_q || spk_ready)) begin
                  state_q     <= StDone;
                  step_done_q <= 1'b1;
                end else begin
                  swept_q <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + ID_WIDTH'(1);
              end
            end
          end else if (!spk_valid_q || spk_ready) begin
            // Last spike handshake done; only now is the step complete.
            spk_valid_q <= 1'b0;
            swept_q     <= 1'b0;
            state_q     <= StDone;
            step_done_q <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vmem_q <= '0;
    end else begin
      rd_vmem_q <= v_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q      <= '0;
      drop_q    <= '0;
      spk_cnt_q <= '0;
    end else if (stats_clear) begin
      ac_q      <= '0;
      drop_q    <= '0;
      spk_cnt_q <= '0;
    end else begin
      if (ev_fire && !ev_refrac) ac_q <= ac_q + 32'd1;
      if (ev_fire && ev_refrac) drop_q <= drop_q + 32'd1;
      if (sweeping && !stall && upd_spike) spk_cnt_q <= spk_cnt_q + 32'd1;
    end
  end

  assign ev_ready          = (state_q == StIdle);
  assign step_done         = step_done_q;
  assign spk_valid         = spk_valid_q;
  assign spk_neuron_id     = spk_id_q;
  assign rd_vmem           = rd_vmem_q;
  assign ac_op_count       = ac_q;
  assign refrac_drop_count = drop_q;
  assign spike_count       = spk_cnt_q;

endmodule

// File: tb/tb_lif_neuron_array_ac.sv
// Self-checking bench for lif_neuron_array_ac (8 neurons, Q8.8, shift 4).
// The reference model keeps membrane values and refractory counters as plain ints
// and applies the neuron rules with ordinary arithmetic.
module tb_lif_neuron_array_ac;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int LS = 4;
  localparam int RW = 4;
  localparam int IW = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ev_valid;
  logic                 ev_ready;
  logic        [IW-1:0] ev_neuron_id;
  logic signed [WW-1:0] ev_weight;
  logic                 ev_excitatory;
  logic                 step_start;
  logic                 step_done;
  logic        [1:0]    leak_mode;
  logic        [DW-1:0] leak_const;
  logic signed [DW-1:0] threshold;
  logic signed [DW-1:0] reset_potential;
  logic        [RW-1:0] refrac_cycles;
  logic                 spk_valid;
  logic                 spk_ready;
  logic        [IW-1:0] spk_neuron_id;
  logic        [IW-1:0] rd_addr;
  logic signed [DW-1:0] rd_vmem;
  logic        [31:0]   ac_op_count;
  logic        [31:0]   refrac_drop_count;
  logic        [31:0]   spike_count;
  logic                 stats_clear;

  always #5 clk = ~clk;

  lif_neuron_array_ac #(
    .NUM_NEURONS (N),
    .DATA_WIDTH  (DW),
    .WEIGHT_WIDTH(WW),
    .LEAK_SHIFT  (LS),
    .REFRAC_WIDTH(RW),
    .ID_WIDTH    (IW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ev_valid         (ev_valid),
    .ev_ready         (ev_ready),
    .ev_neuron_id     (ev_neuron_id),
    .ev_weight        (ev_weight),
    .ev_excitatory    (ev_excitatory),
    .step_start       (step_start),
    .step_done        (step_done),
    .leak_mode        (leak_mode),
    .leak_const       (leak_const),
    .threshold        (threshold),
    .reset_potential  (reset_potential),
    .refrac_cycles    (refrac_cycles),
    .spk_valid        (spk_valid),
    .spk_ready        (spk_ready),
    .spk_neuron_id    (spk_neuron_id),
    .rd_addr          (rd_addr),
    .rd_vmem          (rd_vmem),
    .ac_op_count      (ac_op_count),
    .refrac_drop_count(refrac_drop_count),
    .spike_count      (spike_count),
    .stats_clear      (stats_clear)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int mv[N];
  int mc[N];
  int m_ac, m_drop, m_spk;
  int thr_i, rp_i, mode_i, lc_i, rc_i;
  int exp_q[$];
  int got_q[$];

  function automatic int clamp16(int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int floor_div(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_leak(int v);
    case (mode_i)
      1: return v - floor_div(v, 1 << LS);
      2: begin
        if (v > 0) return (v > lc_i) ? v - lc_i : 0;
        if (v < 0) return (-v > lc_i) ? v + lc_i : 0;
        return 0;
      end
      default: return v;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mc[i] = 0;
    end
    m_ac = 0; m_drop = 0; m_spk = 0;
  endfunction

  function automatic void model_event(int id, int w, bit exc);
    if (mc[id] > 0) begin
      m_drop++;
    end else begin
      mv[id] = clamp16(exc ? mv[id] + w : mv[id] - w);
      m_ac++;
    end
  endfunction

  function automatic void model_sweep();
    int lv;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (mc[i] > 0) begin
        mc[i]--;
        mv[i] = rp_i;
      end else begin
        lv = model_leak(mv[i]);
        if (lv >= thr_i) begin
          mv[i] = rp_i;
          mc[i] = rc_i;
          exp_q.push_back(i);
          m_spk++;
        end else begin
          mv[i] = lv;
        end
      end
    end
  endfunction

  task automatic set_cfg(int thr, int rp, int mode, int lc, int rc);
    thr_i = thr; rp_i = rp; mode_i = mode; lc_i = lc; rc_i = rc;
    threshold       = 16'(thr);
    reset_potential = 16'(rp);
    leak_mode       = 2'(mode);
    leak_const      = 16'(lc);
    refrac_cycles   = 4'(rc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic send_event(int id, int w, bit exc, bit clr);
    n_checks++;
    if (ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ev_ready_idle: got %b need 1", ev_ready);
    end
    ev_valid      = 1'b1;
    ev_neuron_id  = 3'(id);
    ev_weight     = 8'(w);
    ev_excitatory = exc;
    stats_clear   = clr;
    @(negedge clk);
    ev_valid    = 1'b0;
    stats_clear = 1'b0;
    model_event(id, w, exc);
    if (clr) begin
      m_ac = 0; m_drop = 0; m_spk = 0;
    end
  endtask

  task automatic set_v(int id, int target);
    int d;
    for (int k = 0; k < 600 && mv[id] != target; k++) begin
      d = target - mv[id];
      if (d > 127) send_event(id, 127, 1'b1, 1'b0);
      else if (d < -127) send_event(id, 127, 1'b0, 1'b0);
      else if (d > 0) send_event(id, d, 1'b1, 1'b0);
      else send_event(id, -d, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_clear();
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    m_ac = 0; m_drop = 0; m_spk = 0;
  endtask

  // mode 0: always ready, 1: ready low for the first 4 valid cycles, 2: random
  // ready plus ignored junk events/step requests during the sweep.
  task automatic do_step(int mode, bit with_ev, int eid, int ew, bit eexc);
    bit            done;
    int            cycles;
    int            low_left;
    bit            prev_hold;
    logic [IW-1:0] prev_id;
    bit            r;
    int            exp_cycles;
    if (with_ev) model_event(eid, ew, eexc);
    model_sweep();
    got_q.delete();
    done = 1'b0; cycles = 0; low_left = 4; prev_hold = 1'b0; prev_id = '0;
    step_start = 1'b1;
    if (with_ev) begin
      ev_valid = 1'b1; ev_neuron_id = 3'(eid); ev_weight = 8'(ew); ev_excitatory = eexc;
    end
    spk_ready = 1'b1;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      step_start = 1'b0;
      ev_valid   = 1'b0;
      if (cycles == 1) begin
        n_checks++;
        if (ev_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ev_ready_sweep: got %b need 0", ev_ready);
        end
      end
      if (prev_hold) begin
        n_checks++;
        if (spk_valid !== 1'b1 || spk_neuron_id !== prev_id) begin
          n_fail++;
          $display("FAIL spk_hold: got valid=%b id=%0d need valid=1 id=%0d",
                   spk_valid, spk_neuron_id, prev_id);
        end
      end
      if (step_done === 1'b1) begin
        done = 1'b1;
        n_checks++;
        if (spk_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL done_with_pending_spike: got spk_valid=%b need 0", spk_valid);
        end
      end else begin
        if (mode == 1) begin
          r = !(spk_valid && low_left > 0);
          if (spk_valid && low_left > 0) low_left--;
        end else if (mode == 2) begin
          r = ($urandom_range(0, 2) != 0);
        end else begin
          r = 1'b1;
        end
        spk_ready = r;
        if (spk_valid === 1'b1 && r) got_q.push_back(int'(spk_neuron_id));
        prev_hold = (spk_valid === 1'b1) && !r;
        prev_id   = spk_neuron_id;
        if (mode == 2) begin
          ev_valid      = 1'($urandom_range(0, 1));
          ev_neuron_id  = 3'($urandom);
          ev_weight     = 8'($urandom);
          ev_excitatory = 1'b1;
          step_start    = 1'($urandom_range(0, 1));
        end
      end
    end
    step_start = 1'b0;
    ev_valid   = 1'b0;
    spk_ready  = 1'b1;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL step_timeout: got no step_done in %0d cycles need done", cycles);
    end
    if (mode == 0) begin
      exp_cycles = N + 1 + ((exp_q.size() > 0 && exp_q[exp_q.size()-1] == N - 1) ? 1 : 0);
      n_checks++;
      if (cycles != exp_cycles) begin
        n_fail++;
        $display("FAIL step_latency: got %0d need %0d", cycles, exp_cycles);
      end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL spike_count_in_step: got %0d need %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] != exp_q[i]) begin
          n_fail++;
          $display("FAIL spike_order[%0d]: got id %0d need id %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (step_done !== 1'b0 || ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_done: got step_done=%b ev_ready=%b need 0/1", step_done, ev_ready);
    end
  endtask

  task automatic check_vmem();
    for (int i = 0; i < N; i++) begin
      rd_addr = 3'(i);
      @(negedge clk);
      n_checks++;
      if (rd_vmem !== 16'(mv[i])) begin
        n_fail++;
        $display("FAIL vmem[%0d]: got %0d need %0d", i, rd_vmem, mv[i]);
      end
    end
  endtask

  task automatic check_stats();
    n_checks++;
    if (ac_op_count !== 32'(m_ac) || refrac_drop_count !== 32'(m_drop) ||
        spike_count !== 32'(m_spk)) begin
      n_fail++;
      $display("FAIL stats: got ac=%0d drop=%0d spk=%0d need ac=%0d drop=%0d spk=%0d",
               ac_op_count, refrac_drop_count, spike_count, m_ac, m_drop, m_spk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (spk_valid !== 1'b0 || step_done !== 1'b0 || rd_vmem !== '0 ||
        ac_op_count !== '0 || refrac_drop_count !== '0 || spike_count !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got spk_valid=%b step_done=%b rd_vmem=%0d need all 0",
               spk_valid, step_done, rd_vmem);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ev_ready: got %b need 1", ev_ready);
    end
    check_vmem();
  endtask

  task automatic test_basic_spike();
    do_reset();
    set_cfg(256, 0, 0, 0, 2);
    repeat (3) send_event(3, 100, 1'b1, 1'b0);
    do_step(0, 1'b0, 0, 0, 1'b0);
    check_vmem();
    check_stats();
  endtask

  task automatic test_saturation();
    do_reset();
    set_cfg(32767, 0, 0, 0, 0);
    set_v(0, 32700);
    set_v(1, -32760);
    pulse_clear();
    send_event(0, 100, 1'b1, 1'b0);
    send_event(1, 100, 1'b0, 1'b0);
    check_vmem();
    check_stats();
    // Clear wins over a same-cycle increment; the membrane still integrates.
    send_event(2, -20, 1'b1, 1'b1);
    check_vmem();
    check_stats();
  endtask

  task automatic test_leak();
    do_reset();
    set_cfg(32767, 0, 1, 0, 0);
    set_v(0, 160);
    set_v(1, -160);
    set_v(2, 7);
    do_step(0, 1'b0, 0, 0, 1'b0);
    check_vmem();
    set_cfg(32767, 0, 2, 8, 0);
    set_v(2, 5);
    set_v(3, -5);
    set_v(4, 100);
    set_v(5, -100);
    do_step(0, 1'b0, 0, 0, 1'b0);
    check_vmem();
    set_cfg(32767, 0, 3, 8, 0);
    do_step(0, 1'b0, 0, 0, 1'b0);
    check_vmem();
  endtask

  task automatic test_stall();
    do_reset();
    set_cfg(256, 0, 0, 0, 0);
    set_v(1, 300);
    set_v(5, 300);
    do_step(1, 1'b0, 0, 0, 1'b0);
    check_vmem();
    check_stats();
  endtask

  task automatic test_refrac();
    do_reset();
    set_cfg(256, 0, 0, 0, 2);
    set_v(2, 300);
    do_step(0, 1'b0, 0, 0, 1'b0);
    send_event(2, 50, 1'b1, 1'b0);
    check_vmem();
    check_stats();
    do_step(0, 1'b0, 0, 0, 1'b0);
    do_step(0, 1'b0, 0, 0, 1'b0);
    send_event(2, 50, 1'b1, 1'b0);
    check_vmem();
    check_stats();
  endtask

  task automatic test_reset_mid_sweep();
    bit saw_done;
    do_reset();
    set_cfg(256, 0, 0, 0, 1);
    set_v(0, 300);
    set_v(6, 300);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (spk_valid !== 1'b0 || step_done !== 1'b0 || ev_ready !== 1'b1 || rd_vmem !== '0) begin
      n_fail++;
      $display("FAIL midsweep_reset: got spk_valid=%b step_done=%b ev_ready=%b rd_vmem=%0d need 0/0/1/0",
               spk_valid, step_done, ev_ready, rd_vmem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_stats();
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (step_done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL midsweep_no_done: got step_done=1 need 0");
    end
    check_vmem();
    set_v(6, 300);
    set_v(2, 300);
    do_step(0, 1'b0, 0, 0, 1'b0);
    check_vmem();
    check_stats();
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 14; r++) begin
      set_cfg(int'($urandom_range(0, 700)) - 100, int'($urandom_range(0, 100)) - 50,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 3)));
      for (int e = int'($urandom_range(0, 20)); e > 0; e--) begin
        send_event(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)) - 128,
                   1'($urandom_range(0, 1)), 1'b0);
      end
      if (r % 5 == 4) pulse_clear();
      if ($urandom_range(0, 1) == 1) begin
        // Event and timestep request in the same idle cycle.
        do_step(2, 1'b1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 127)), 1'b1);
      end else begin
        do_step(2, 1'b0, 0, 0, 1'b0);
      end
      check_vmem();
      check_stats();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ev_valid = 1'b0; ev_neuron_id = '0; ev_weight = '0; ev_excitatory = 1'b1;
    step_start = 1'b0; spk_ready = 1'b1; rd_addr = '0; stats_clear = 1'b0;
    set_cfg(256, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_basic_spike();
    test_saturation();
    test_leak();
    test_stall();
    test_refrac();
    test_reset_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array_ac.md
LIF_NEURON_ARRAY_AC -- requirements
Module: lif_neuron_array_ac

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 16: neurons time-multiplexed in one datapath.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed Q8.8 membrane width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8: signed INT8 weight width.
REQ-004 SHALL have parameter LEAK_SHIFT, default 4: shift-leak exponent.
REQ-005 SHALL have parameter REFRAC_WIDTH, default 4: refractory counter width.
REQ-006 SHALL have parameter ID_WIDTH, default $clog2(NUM_NEURONS): neuron index width.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 ev_valid/ev_ready  in/out  1/1  synaptic event handshake.
REQ-010 ev_neuron_id  in  ID_WIDTH  target neuron; ev_weight  in  WEIGHT_WIDTH signed; ev_excitatory  in  1 (1 add, 0 subtract).
REQ-011 step_start  in  1  timestep request; step_done  out  1  one-cycle pulse at sweep end.
REQ-012 leak_mode  in  2  0 none, 1 shift, 2 linear, 3 reserved (acts as 0); leak_const  in  DATA_WIDTH  linear leak amount.
REQ-013 threshold, reset_potential  in  DATA_WIDTH signed; refrac_cycles  in  REFRAC_WIDTH.
REQ-014 spk_valid/spk_ready  out/in  1/1  output spike handshake; spk_neuron_id  out  ID_WIDTH.
REQ-015 rd_addr  in  ID_WIDTH; rd_vmem  out  DATA_WIDTH  membrane readback, 1-cycle latency.
REQ-016 ac_op_count, refrac_drop_count, spike_count  out  32 each; stats_clear  in  1.

Function
REQ-017 FSM states IDLE, SWEEP, DONE; IDLE->SWEEP on step_start; SWEEP->DONE after neuron NUM_NEURONS-1 updated; DONE->IDLE next cycle, step_done=1 in DONE only.
REQ-018 ev_ready=1 only in IDLE; one event accepted per cycle.
REQ-019 Accepted event to non-refractory neuron: v +/- sign-extended weight, saturating to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; ac_op_count+1; no multiply.
REQ-020 Accepted event to refractory neuron (counter>0): v unchanged; refrac_drop_count+1.
REQ-021 ev_valid and step_start same IDLE cycle: event integrated, then SWEEP entered next cycle.
REQ-022 SWEEP: one neuron per cycle, ascending index from 0.
REQ-023 Refractory neuron in sweep: counter-1, v=reset_potential, no spike.
REQ-024 Else leak: mode1 v-(v>>>LEAK_SHIFT); mode2 move v toward 0 by leak_const, clamped at 0 (no sign crossing); mode0/3 unchanged.
REQ-025 Post-leak v >= threshold (signed): v=reset_potential, counter=refrac_cycles, spike issued with neuron index, spike_count+1.
REQ-026 spk_valid registered, held with stable spk_neuron_id until spk_ready; sweep stalls (index held, no update) while spk_valid=1 and spk_ready=0 and next neuron would spike.
REQ-027 Sweep latency NUM_NEURONS cycles plus stall cycles; step_done not asserted before last spike handshake completes.
REQ-028 step_start outside IDLE ignored.
REQ-029 Counters wrap at 2^32; stats_clear zeroes all three, overriding same-cycle increment.
REQ-030 rd_vmem returns v[rd_addr] as of previous clock edge.

Reset
REQ-031 rst_n low: all v=0, counters=0, FSM=IDLE, spk_valid=0, step_done=0, rd_vmem=0, stats=0; ev_ready=1 after release.
REQ-032 Reset mid-sweep aborts sweep; no step_done, pending spike discarded.

Structure
REQ-033 Package snn_lif_pkg SHALL hold FSM state encoding, leak_mode encodings, saturation min/max constants.
REQ-034 One sub-module lif_update_ac SHALL implement combinational leak/threshold/refractory update for one neuron, reused by the sweep.
REQ-035 Neuron state SHALL be register arrays (v, counter), distributed-RAM inferable.

Verification (NUM_NEURONS=8, Q8.8, LEAK_SHIFT=4)
REQ-036 Three events n3 w=+100, threshold=256, mode0, refrac=2, step -> spk id3, v3=reset 0, step_done after 8 cycles.
REQ-037 v=32700 +100 -> 32767; v=-32760 inhibitory w=100 -> -32768; ac_op_count=2.
REQ-038 v=160 mode1 -> 150; v=-160 -> -150; v=5 mode2 leak_const=8 -> 0.
REQ-039 n1,n5 above threshold, spk_ready low 4 cycles -> id1 held, sweep stalls, then id5; step_done after both handshakes.
REQ-040 Event to refractory n2 -> v2 unchanged, refrac_drop_count=1; after 2 steps event integrates.
REQ-041 rst_n low at sweep index 4 -> all outputs reset, no step_done, next step sweeps from 0.
